// File: rtl/sram_1r1w_be.sv
// 1R1W synchronous SRAM with byte enables, write-first collision forwarding and optional output register.
// Latency 1+OUT_REG cycles; there is no backpressure, and requests are ignored while ready is low. Define SRAM_1R1W_ZERO_INIT_EN to add the post-reset zero-fill sweep.
module sram_1r1w_be #(
    parameter int ADDR_SZ = 9,
    parameter int DATA_SZ = 64,
    parameter int MEM_SZ  = 512,
    parameter int OUT_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   ready,
    input  logic                   write_en,
    input  logic [ADDR_SZ-1:0]     write_addr,
    input  logic [DATA_SZ-1:0]     write_data,
    input  logic [DATA_SZ/8-1:0]   write_be,
    input  logic                   read_en,
    input  logic [ADDR_SZ-1:0]     read_addr,
    output logic [DATA_SZ-1:0]     read_data,
    output logic                   read_valid
);

    localparam int BE_SZ = DATA_SZ / 8;
    localparam logic [ADDR_SZ:0] MEM_LIM = (ADDR_SZ+1)'(MEM_SZ);

    logic [DATA_SZ-1:0] mem [MEM_SZ];

    logic               wr_ok;
    logic               rd_acc;
    logic               rd_in_range;
    logic [ADDR_SZ-1:0] rd_idx;
    logic [DATA_SZ-1:0] rd_word;

    logic               sweep_we;
    logic [ADDR_SZ-1:0] sweep_addr;

    logic               mem_we;
    logic [ADDR_SZ-1:0] mem_waddr;
    logic [DATA_SZ-1:0] mem_wdata;
    logic [BE_SZ-1:0]   mem_wbe;

    logic               vld1;
    logic [DATA_SZ-1:0] data1;

    assign wr_ok       = ready & write_en & ({1'b0, write_addr} < MEM_LIM);
    assign rd_acc      = ready & read_en;
    assign rd_in_range = {1'b0, read_addr} < MEM_LIM;
    assign rd_idx      = rd_in_range ? read_addr : '0;

`ifdef SRAM_1R1W_ZERO_INIT_EN
    localparam logic [ADDR_SZ-1:0] LAST_ADDR = ADDR_SZ'(MEM_SZ - 1);

    typedef enum logic {INIT, RUN} state_t;
    state_t             state;
    logic [ADDR_SZ-1:0] clr_addr;

    // ready is registered off RUN, so it rises one edge after the last word is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR)
                        state <= RUN;
                end
                RUN:     ready <= 1'b1;
                default: state <= INIT;
            endcase
        end
    end

    assign sweep_we   = (state == INIT);
    assign sweep_addr = clr_addr;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ready <= 1'b0;
        else
            ready <= 1'b1;
    end

    assign sweep_we   = 1'b0;
    assign sweep_addr = '0;
`endif

    always_comb begin
        mem_we    = wr_ok;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        mem_wbe   = write_be;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_wdata = '0;
            mem_wbe   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_SZ; i++)
                if (mem_wbe[i])
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // Write-first: bytes being written this cycle to the same word override the array value.
    always_comb begin
        rd_word = rd_in_range ? mem[rd_idx] : '0;
        if (rd_in_range && wr_ok && (write_addr == read_addr)) begin
            for (int i = 0; i < BE_SZ; i++)
                if (write_be[i])
                    rd_word[8*i +: 8] = write_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1  <= 1'b0;
            data1 <= '0;
        end else begin
            vld1 <= rd_acc;
            if (rd_acc)
                data1 <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic               vld2;
        logic [DATA_SZ-1:0] data2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld2  <= 1'b0;
                data2 <= '0;
            end else begin
                vld2 <= vld1;
                if (vld1)
                    data2 <= data1;
            end
        end

        assign read_valid = vld2;
        assign read_data  = data2;
    end else begin : g_no_out_reg
        assign read_valid = vld1;
        assign read_data  = data1;
    end

endmodule

// File: tb/tb_sram_1r1w_be.sv
// Scoreboard bench driving two sram_1r1w_be instances with shared stimulus:
// a = 12 words with output register, b = 16 words without.
module tb_sram_1r1w_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        write_en, read_en;
    logic [3:0]  write_addr, read_addr;
    logic [63:0] write_data;
    logic [7:0]  write_be;
    logic        ready_a, ready_b, valid_a, valid_b;
    logic [63:0] data_a, data_b;

    sram_1r1w_be #(.ADDR_SZ(4), .DATA_SZ(64), .MEM_SZ(12), .OUT_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ready(ready_a),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
        .read_en(read_en), .read_addr(read_addr), .read_data(data_a), .read_valid(valid_a)
    );

    sram_1r1w_be #(.ADDR_SZ(4), .DATA_SZ(64), .MEM_SZ(16), .OUT_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ready(ready_b),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
        .read_en(read_en), .read_addr(read_addr), .read_data(data_b), .read_valid(valid_b)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q_a[$], q_b[$];
    logic [63:0] model_a[16], model_b[16];
    logic [63:0] last_a, last_b;
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] expect_rd(input logic is_a, input logic we, input logic [3:0] wa,
                                              input logic [63:0] wd, input logic [7:0] wbe,
                                              input logic [3:0] ra);
        int          lim;
        logic [63:0] w;
        lim = is_a ? 12 : 16;
        if (int'(ra) >= lim) return 64'h0;
        w = is_a ? model_a[ra] : model_b[ra];
        if (we && wa == ra)
            for (int i = 0; i < 8; i++)
                if (wbe[i]) w[8*i +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    // Drive one cycle of requests; expectations are queued and the models updated here.
    task automatic op(input logic we, input logic [3:0] wa, input logic [63:0] wd, input logic [7:0] wbe,
                      input logic re, input logic [3:0] ra);
        exp_t e;
        write_en = we; write_addr = wa; write_data = wd; write_be = wbe;
        read_en = re;  read_addr = ra;
        if (re) begin
            e.cyc = cyc;
            e.data = expect_rd(1'b1, we, wa, wd, wbe, ra);
            q_a.push_back(e);
            e.data = expect_rd(1'b0, we, wa, wd, wbe, ra);
            q_b.push_back(e);
        end
        if (we)
            for (int i = 0; i < 8; i++)
                if (wbe[i]) begin
                    if (int'(wa) < 12) model_a[wa][8*i +: 8] = wd[8*i +: 8];
                    model_b[wa][8*i +: 8] = wd[8*i +: 8];
                end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'd0, 64'h0, 8'h0, 1'b0, 4'd0);
    endtask

    task automatic release_and_measure(input int exp_a, input int exp_b);
        int ea, eb;
        ea = -1;
        eb = -1;
        rst_n = 1'b1;
        for (int n = 1; n <= 64 && (ea < 0 || eb < 0); n++) begin
            @(posedge clk); #1;
            if (ready_a && ea < 0) ea = n;
            if (ready_b && eb < 0) eb = n;
        end
        check("a_ready_edges", 64'(ea), 64'(exp_a));
        check("b_ready_edges", 64'(eb), 64'(exp_b));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            last_a = '0;
            last_b = '0;
        end else begin
            if (valid_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_valid: got read_valid=1 data %h expected no read", data_a);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", data_a, e.data);
                    check("a_latency", 64'(cyc - e.cyc), 64'd2);
                end
                last_a = data_a;
            end else
                check("a_hold", data_a, last_a);

            if (valid_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_valid: got read_valid=1 data %h expected no read", data_b);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", data_b, e.data);
                    check("b_latency", 64'(cyc - e.cyc), 64'd1);
                end
                last_b = data_b;
            end else
                check("b_hold", data_b, last_b);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        write_en = 0; write_addr = 0; write_data = 0; write_be = 0;
        read_en = 0;  read_addr = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_ready", ready_a, 0);
        check("a_reset_valid", valid_a, 0);
        check("a_reset_data", data_a, 0);
        check("b_reset_ready", ready_b, 0);
        check("b_reset_valid", valid_b, 0);
        check("b_reset_data", data_b, 0);

`ifdef SRAM_1R1W_ZERO_INIT_EN
        // Reset at sweep cycle 6 with reads pending that must be ignored.
        rst_n = 1'b1;
        read_en = 1'b1;
        read_addr = 4'd0;
        repeat (6) @(posedge clk);
        #1;
        check("a_ready_mid_sweep", ready_a, 0);
        check("b_ready_mid_sweep", ready_b, 0);
        rst_n = 1'b0;
        read_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release_and_measure(13, 17);
`else
        release_and_measure(1, 1);
        for (int a = 0; a < 16; a++) op(1'b1, 4'(a), 64'h0, 8'hFF, 1'b0, 4'd0);
`endif

        for (int a = 0; a < 16; a++) op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'(a));

        op(1'b1, 4'd5, 64'h1111_1111_1111_1111, 8'hFF, 1'b0, 4'd0);
        op(1'b1, 4'd5, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b0, 4'd0);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd5);

        op(1'b1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 1'b1, 4'd7);
        op(1'b1, 4'd7, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b1, 4'd7);

        op(1'b1, 4'd1, 64'h0000_0000_0000_0101, 8'hFF, 1'b0, 4'd0);
        op(1'b1, 4'd2, 64'h0000_0000_0000_0202, 8'hFF, 1'b0, 4'd0);
        op(1'b1, 4'd3, 64'h0000_0000_0000_0303, 8'hFF, 1'b0, 4'd0);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd1);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd2);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd3);

        op(1'b1, 4'd2, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b1, 4'd2);
        op(1'b1, 4'd4, 64'h4444_4444_4444_4444, 8'hFF, 1'b1, 4'd3);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd4);

        op(1'b1, 4'd13, 64'h0000_0000_0000_0055, 8'hFF, 1'b0, 4'd0);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd13);
        for (int a = 0; a < 12; a++) op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'(a));
        idle(4);

        // Reset with reads still in the pipeline: they must vanish.
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd5);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd6);
        read_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("a_inflight_valid", valid_a, 0);
        check("a_inflight_data", data_a, 0);
        check("b_inflight_valid", valid_b, 0);
        check("b_inflight_data", data_b, 0);
        repeat (2) @(posedge clk);
        #1;
`ifdef SRAM_1R1W_ZERO_INIT_EN
        for (int i = 0; i < 16; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        release_and_measure(13, 17);
`else
        release_and_measure(1, 1);
`endif
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd5);
        op(1'b0, 4'd0, 64'h0, 8'h0, 1'b1, 4'd7);
        idle(5);

        check("a_drain", 64'(q_a.size()), 64'd0);
        check("b_drain", 64'(q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
